mpu_alu_seq: RTL and testbench
==============================

Name: mpu_alu_seq

Overview:
- Sequencer that runs a program of check descriptors through one combinational mpu_alu instance held in the parent.
- Per descriptor: fetch from a synchronous descriptor ROM/RAM, read three 64-bit operands from the MPU register file, drive the ALU, and fold the boolean result into a verdict and a lane accumulator.
- Started by the MPU top on each access to validate; reports done, pass/fail and error.

Parameters:
- AW, 8, descriptor memory address width
- MAXLEN, 64, max descriptors per run; run aborts with err when reached without a last bit

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; ignored unless idle
- base  in  AW  first descriptor address, sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of run
- pass  out  1  verdict, valid when done=1, held until next start
- err  out  1  illegal op or MAXLEN overrun, valid with done, held until next start
- acc  out  64  OR of all ALU results of the run, held until next start
- dm_rd  out  1  descriptor read strobe
- dm_addr  out  AW  descriptor address
- dm_data  in  32  descriptor; valid the cycle after dm_rd
- rf_a0, rf_a1, rf_a2  out  3 each  register file read indices
- rf_d0, rf_d1, rf_d2  in  64 each  combinational read data
- alu_size  out  2; alu_op  out  4; alu_o0/o1/o2  out  64 each; alu_s0/s1/s2/alu_sres  out  3 each  ALU operand bus
- alu_res  in  64  ALU result (combinational)

Behaviour:
- Reset (sys_rst_n low, async): state IDLE; busy=0, done=0, pass=0, err=0, acc=0, dm_rd=0, dm_addr=0; all alu_* and rf_* outputs 0, alu_op=0 (none).
- Descriptor word: [3:0] op, [5:4] size, [8:6] s0, [11:9] s1, [14:12] s2, [17:15] sres, [20:18] r0, [23:21] r1, [26:24] r2, [27] last, [28] stop_on_fail, [31:29] reserved, ignored.
- FSM states: IDLE, FETCH, WAIT, EXEC, FIN.
- IDLE:
  - On start: pc<=base, cnt<=0, acc<=0, pass<=1, err<=0, busy<=1, then FETCH.
- FETCH:
  - dm_rd=1, dm_addr=pc for one cycle, then WAIT.
- WAIT:
  - Capture dm_data into descriptor register d.
  - If d.op>3: err<=1, pass<=0, go FIN.
  - Otherwise go EXEC.
- EXEC:
  - Outputs driven from d: alu_op, size, s*, sres; rf_a0..2=r0..r2; alu_o0..2=rf_d0..2.
  - These fields are registered; alu_o* is a combinational pass-through.
  - At the clock edge: acc<=acc|alu_res; ok=(alu_res!=0); pass<=pass&ok; cnt<=cnt+1; pc<=pc+1.
  - pc wraps mod 2^AW silently.
  - Next state:
    - FIN if last=1, or (stop_on_fail=1 and ok=0).
    - Otherwise FIN with err<=1, pass<=0 if cnt+1==MAXLEN.
    - Otherwise FETCH.
  - alu_op returns to 0 outside EXEC.
- FIN:
  - done=1 for one cycle, busy<=0, then IDLE.
  - pass/err/acc remain stable until the next accepted start.
- Timing:
  - 3 cycles per descriptor.
  - Run of N descriptors: done asserted N*3+1 cycles after the start cycle.
  - Start and done are never in the same cycle.
- op=0 (none) is legal: res=0, so it fails pass. Programs use it only as a fail marker.
- start while busy: ignored; no queuing.
- Reset mid-run: run abandoned, no done pulse, outputs return to reset values.
- Simultaneous error and last in WAIT: the error wins.

Decomposition:
- Shared package mpu_pkg:
  - ALU op codes (NONE=0, MASK=1, CMP=2, LT=3)
  - size codes (B=0, W=1, DW=2, QW=3)
  - descriptor field bit positions
  - FSM state encoding
- No sub-module. The ALU stays instantiated in the parent so other requesters can share it later.

Test Plan:
- Single CMP, size=0, r0=r1 with o0=o1=64'h12, o2 mask=64'hFF, sres=0, last=1 -> done at start+4, pass=1, acc=1, err=0.
- Three descriptors LT(1<2), MASK passing, CMP failing with stop_on_fail=0 -> all 3 executed, done at start+10, pass=0, acc shows bits at each sres lane (sres=0,1,2 at size=0 -> acc=64'h0101).
- Same program with stop_on_fail=1 on descriptor 2 failing -> stops after descriptor 2, done at start+7, pass=0.
- Descriptor with op=5 -> err=1, pass=0, no EXEC cycle, done at start+3.
- No last bit anywhere with MAXLEN=4, base=8'hFE -> dm_addr sequence FE,FF,00,01 (wrap), err=1 after the 4th descriptor.
- Deassert sys_rst_n during WAIT, and separately pulse start while busy -> async clear of all outputs, no done; extra start has no effect on cnt or pc.

Source files
------------

// File: rtl/mpu_pkg.sv
// Shared MPU definitions: ALU op and size codes, check-descriptor layout, sequencer FSM encoding.
// Pure declarations; no logic, no latency, no flow control.
package mpu_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_MASK = 4'd1,
    OP_CMP  = 4'd2,
    OP_LT   = 4'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    SZ_B  = 2'd0,
    SZ_W  = 2'd1,
    SZ_DW = 2'd2,
    SZ_QW = 2'd3
  } alu_size_e;

  localparam int DF_OP_LSB   = 0;
  localparam int DF_OP_MSB   = 3;
  localparam int DF_SIZE_LSB = 4;
  localparam int DF_S0_LSB   = 6;
  localparam int DF_S1_LSB   = 9;
  localparam int DF_S2_LSB   = 12;
  localparam int DF_SRES_LSB = 15;
  localparam int DF_R0_LSB   = 18;
  localparam int DF_R1_LSB   = 21;
  localparam int DF_R2_LSB   = 24;
  localparam int DF_LAST     = 27;
  localparam int DF_STOP     = 28;
  localparam int DESC_W      = 29;

  // Bits [31:29] of the descriptor word are reserved and never stored.
  typedef struct packed {
    logic       stop_on_fail;
    logic       last;
    logic [2:0] r2;
    logic [2:0] r1;
    logic [2:0] r0;
    logic [2:0] sres;
    logic [2:0] s2;
    logic [2:0] s1;
    logic [2:0] s0;
    logic [1:0] size;
    logic [3:0] op;
  } desc_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

endpackage

// File: rtl/mpu_alu_seq.sv
// Runs a descriptor program through the parent's shared ALU; 3 cycles per descriptor, done at N*3+1 after start.
// No backpressure: start is dropped while busy, descriptor memory must answer one cycle after dm_rd.
module mpu_alu_seq
  import mpu_pkg::*;
#(
  parameter int AW     = 8,
  parameter int MAXLEN = 64
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          start,
  input  logic [AW-1:0] base,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          err,
  output logic [63:0]   acc,
  output logic          dm_rd,
  output logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_data,
  output logic [2:0]    rf_a0,
  output logic [2:0]    rf_a1,
  output logic [2:0]    rf_a2,
  input  logic [63:0]   rf_d0,
  input  logic [63:0]   rf_d1,
  input  logic [63:0]   rf_d2,
  output logic [1:0]    alu_size,
  output logic [3:0]    alu_op,
  output logic [63:0]   alu_o0,
  output logic [63:0]   alu_o1,
  output logic [63:0]   alu_o2,
  output logic [2:0]    alu_s0,
  output logic [2:0]    alu_s1,
  output logic [2:0]    alu_s2,
  output logic [2:0]    alu_sres,
  input  logic [63:0]   alu_res
);

  localparam int CW = $clog2(MAXLEN + 1);

  logic [2:0]    r_state;
  logic [AW-1:0] r_pc;
  logic [CW-1:0] r_cnt;
  desc_t         r_d;
  logic          r_busy;
  logic          r_pass;
  logic          r_err;
  logic [63:0]   r_acc;

  logic          w_exec;
  logic          w_ok;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_overrun;
  logic          w_bad_op;
  logic          w_unused_rsvd;

  assign w_exec        = (r_state == ST_EXEC);
  assign w_ok          = |alu_res;
  assign w_cnt_nxt     = r_cnt + CW'(1);
  assign w_overrun     = (w_cnt_nxt == CW'(MAXLEN));
  assign w_bad_op      = (dm_data[DF_OP_MSB:DF_OP_LSB] > OP_LT);
  assign w_unused_rsvd = ^dm_data[31:DESC_W];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
      r_d     <= '0;
      r_busy  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= 1'b0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_pc    <= base;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_pass  <= 1'b1;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: r_state <= ST_WAIT;
        ST_WAIT: begin
          r_d <= desc_t'(dm_data[DESC_W-1:0]);
          // An illegal op ends the run before EXEC, even if its last bit is set.
          if (w_bad_op) begin
            r_err   <= 1'b1;
            r_pass  <= 1'b0;
            r_state <= ST_FIN;
          end else begin
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_acc  <= r_acc | alu_res;
          r_pass <= r_pass & w_ok;
          r_cnt  <= w_cnt_nxt;
          r_pc   <= r_pc + AW'(1);
          if (r_d.last || (r_d.stop_on_fail && !w_ok)) begin
            r_state <= ST_FIN;
          end else if (w_overrun) begin
            r_err   <= 1'b1;
            r_pass  <= 1'b0;
            r_state <= ST_FIN;
          end else begin
            r_state <= ST_FETCH;
          end
        end
        ST_FIN: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = (r_state == ST_FIN);
  assign pass    = r_pass;
  assign err     = r_err;
  assign acc     = r_acc;
  assign dm_rd   = (r_state == ST_FETCH);
  assign dm_addr = r_pc;

  assign rf_a0    = r_d.r0;
  assign rf_a1    = r_d.r1;
  assign rf_a2    = r_d.r2;
  assign alu_size = r_d.size;
  assign alu_s0   = r_d.s0;
  assign alu_s1   = r_d.s1;
  assign alu_s2   = r_d.s2;
  assign alu_sres = r_d.sres;

  // The ALU is shared, so it only sees a real op and operands while this block owns it.
  assign alu_op = w_exec ? r_d.op : OP_NONE;
  assign alu_o0 = w_exec ? rf_d0 : 64'd0;
  assign alu_o1 = w_exec ? rf_d1 : 64'd0;
  assign alu_o2 = w_exec ? rf_d2 : 64'd0;

endmodule

// File: tb/tb_mpu_alu_seq.sv
// Directed bench for mpu_alu_seq with a stand-in ALU, register file and descriptor memory.
module tb_mpu_alu_seq;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        start;
  logic [7:0]  base;
  logic        busy, done, pass, err, dm_rd;
  logic [63:0] acc;
  logic [7:0]  dm_addr;
  logic [31:0] dm_data;
  logic [2:0]  rf_a0, rf_a1, rf_a2;
  logic [63:0] rf_d0, rf_d1, rf_d2;
  logic [1:0]  alu_size;
  logic [3:0]  alu_op;
  logic [63:0] alu_o0, alu_o1, alu_o2;
  logic [2:0]  alu_s0, alu_s1, alu_s2, alu_sres;
  logic [63:0] alu_res;

  logic [31:0] dmem [256];
  logic [63:0] rf [8];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  addr_q [$];
  logic        exec_seen;
  logic [8:0]  exec_sel;
  logic        tb_ok;
  int          tb_sh;

  mpu_alu_seq #(.AW(8), .MAXLEN(4)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .base(base),
    .busy(busy), .done(done), .pass(pass), .err(err), .acc(acc),
    .dm_rd(dm_rd), .dm_addr(dm_addr), .dm_data(dm_data),
    .rf_a0(rf_a0), .rf_a1(rf_a1), .rf_a2(rf_a2),
    .rf_d0(rf_d0), .rf_d1(rf_d1), .rf_d2(rf_d2),
    .alu_size(alu_size), .alu_op(alu_op),
    .alu_o0(alu_o0), .alu_o1(alu_o1), .alu_o2(alu_o2),
    .alu_s0(alu_s0), .alu_s1(alu_s1), .alu_s2(alu_s2), .alu_sres(alu_sres),
    .alu_res(alu_res)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) if (dm_rd) dm_data <= dmem[dm_addr];

  assign rf_d0 = rf[rf_a0];
  assign rf_d1 = rf[rf_a1];
  assign rf_d2 = rf[rf_a2];

  // Stand-in ALU: a passing check sets the lowest bit of lane sres at the given size.
  always_comb begin
    tb_ok = 1'b0;
    case (alu_op)
      4'd1:    tb_ok = ((alu_o0 & alu_o2) != 64'd0);
      4'd2:    tb_ok = ((alu_o0 & alu_o2) == (alu_o1 & alu_o2));
      4'd3:    tb_ok = (alu_o0 < alu_o1);
      default: tb_ok = 1'b0;
    endcase
    tb_sh   = int'(alu_sres) * (8 << int'(alu_size));
    alu_res = (tb_ok && tb_sh < 64) ? (64'd1 << tb_sh) : 64'd0;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [2:0] sres,
                                     input logic [2:0] r0, input logic [2:0] r1, input logic [2:0] r2,
                                     input logic last, input logic sof, input logic [8:0] sel);
    mk = {3'b000, sof, last, r2, r1, r0, sres, sel, 2'b00, op};
  endfunction

  // Start a run at base b; lat is the cycle (start cycle = 0) in which done is seen, -1 on timeout.
  task automatic run(input logic [7:0] b, input int extra_at, input logic [7:0] extra_base,
                     output int lat, output logic busy1);
    lat = -1;
    busy1 = 1'b0;
    exec_seen = 1'b0;
    exec_sel = '0;
    addr_q.delete();
    @(negedge sys_clk);
    base = b;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    busy1 = busy;
    for (int k = 1; k < 100; k++) begin
      if (k == extra_at) begin
        start = 1'b1;
        base = extra_base;
      end else begin
        start = 1'b0;
      end
      if (dm_rd) addr_q.push_back(dm_addr);
      if (alu_op != 4'd0 && !exec_seen) begin
        exec_seen = 1'b1;
        exec_sel = {alu_s2, alu_s1, alu_s0};
      end
      if (done) begin
        lat = k;
        break;
      end
      @(negedge sys_clk);
    end
    start = 1'b0;
  endtask

  int   lat;
  logic b1;
  int   seen;

  initial begin
    sys_rst_n = 1'b0;
    start = 1'b0;
    base = 8'h00;
    for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
    rf[0] = 64'h12; rf[1] = 64'h12; rf[2] = 64'hFF; rf[3] = 64'h1;
    rf[4] = 64'h2;  rf[5] = 64'h34; rf[6] = 64'h0;  rf[7] = 64'h0;

    dmem[8'h10] = mk(4'd2, 3'd0, 3'd0, 3'd1, 3'd2, 1'b1, 1'b0, {3'd3, 3'd2, 3'd1});
    dmem[8'h20] = mk(4'd3, 3'd0, 3'd3, 3'd4, 3'd0, 1'b0, 1'b0, 9'd0);
    dmem[8'h21] = mk(4'd1, 3'd1, 3'd0, 3'd0, 3'd2, 1'b0, 1'b0, 9'd0);
    dmem[8'h22] = mk(4'd2, 3'd2, 3'd0, 3'd5, 3'd2, 1'b1, 1'b0, 9'd0);
    dmem[8'h30] = mk(4'd3, 3'd0, 3'd3, 3'd4, 3'd0, 1'b0, 1'b0, 9'd0);
    dmem[8'h31] = mk(4'd2, 3'd1, 3'd0, 3'd5, 3'd2, 1'b0, 1'b1, 9'd0);
    dmem[8'h32] = mk(4'd1, 3'd2, 3'd0, 3'd0, 3'd2, 1'b1, 1'b0, 9'd0);
    dmem[8'h40] = mk(4'd5, 3'd0, 3'd0, 3'd1, 3'd2, 1'b1, 1'b0, 9'd0);
    dmem[8'hFE] = mk(4'd3, 3'd0, 3'd3, 3'd4, 3'd0, 1'b0, 1'b0, 9'd0);
    dmem[8'hFF] = mk(4'd3, 3'd0, 3'd3, 3'd4, 3'd0, 1'b0, 1'b0, 9'd0);
    dmem[8'h00] = mk(4'd3, 3'd0, 3'd3, 3'd4, 3'd0, 1'b0, 1'b0, 9'd0);
    dmem[8'h01] = mk(4'd3, 3'd0, 3'd3, 3'd4, 3'd0, 1'b0, 1'b0, 9'd0);

    repeat (2) @(negedge sys_clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst pass", pass, 0);
    check("rst err", err, 0);
    check("rst acc", acc, 0);
    check("rst dm_rd", dm_rd, 0);
    check("rst dm_addr", dm_addr, 0);
    check("rst alu_op", alu_op, 0);
    check("rst alu_o0", alu_o0, 0);
    sys_rst_n = 1'b1;

    run(8'h10, 0, 8'h00, lat, b1);
    check("t1 busy", b1, 1);
    check("t1 lat", lat, 4);
    check("t1 pass", pass, 1);
    check("t1 acc", acc, 64'h1);
    check("t1 err", err, 0);
    check("t1 sel", exec_sel, {3'd3, 3'd2, 3'd1});
    @(negedge sys_clk);
    check("t1 done pulse", done, 0);
    check("t1 busy end", busy, 0);
    check("t1 pass hold", pass, 1);

    run(8'h20, 0, 8'h00, lat, b1);
    check("t2 lat", lat, 10);
    check("t2 pass", pass, 0);
    check("t2 acc", acc, 64'h0101);
    check("t2 err", err, 0);

    run(8'h30, 0, 8'h00, lat, b1);
    check("t3 lat", lat, 7);
    check("t3 pass", pass, 0);
    check("t3 acc", acc, 64'h1);
    check("t3 fetches", addr_q.size(), 2);

    run(8'h40, 0, 8'h00, lat, b1);
    check("t4 lat", lat, 3);
    check("t4 err", err, 1);
    check("t4 pass", pass, 0);
    check("t4 exec", exec_seen, 0);
    check("t4 acc", acc, 0);

    run(8'hFE, 0, 8'h00, lat, b1);
    check("t5 lat", lat, 13);
    check("t5 err", err, 1);
    check("t5 pass", pass, 0);
    check("t5 acc", acc, 64'h1);
    check("t5 fetches", addr_q.size(), 4);
    if (addr_q.size() == 4) begin
      check("t5 addr0", addr_q[0], 8'hFE);
      check("t5 addr1", addr_q[1], 8'hFF);
      check("t5 addr2", addr_q[2], 8'h00);
      check("t5 addr3", addr_q[3], 8'h01);
    end

    run(8'h20, 5, 8'h40, lat, b1);
    check("t6 lat", lat, 10);
    check("t6 pass", pass, 0);
    check("t6 err", err, 0);
    check("t6 acc", acc, 64'h0101);
    check("t6 fetches", addr_q.size(), 3);
    if (addr_q.size() == 3) check("t6 addr2", addr_q[2], 8'h22);
    @(negedge sys_clk);
    check("t6 no restart", busy, 0);

    @(negedge sys_clk);
    base = 8'h10;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check("t7 busy", busy, 0);
    check("t7 pass", pass, 0);
    check("t7 done", done, 0);
    check("t7 dm_addr", dm_addr, 0);
    check("t7 dm_rd", dm_rd, 0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge sys_clk);
      if (done || busy) seen++;
    end
    check("t7 no done", seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
